// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int UART_CLK_DIV     = 10416;
  localparam int DEF_BUSY_TIMEOUT = 8;
  localparam int BYTE_W           = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searching from ptr+1 with wrap
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           found
);

  // first set mask bit after ptr, wrapping modulo N (works for non-power-of-2 N)
  always_comb begin
    int p;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 1; k <= N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!found && mask[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = IDW'(p);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter, with packet locking
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_wr,
  output logic [BYTE_W-1:0]         uart_din,
  input  logic                      uart_tx_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      lock_active,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

  state_t             state, state_next;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] cand_oh;
  logic [ID_W-1:0]    cand_idx;
  logic               cand_found;
  logic               accept;
  logic               timeout_hit;
  logic [BYTE_W-1:0]  cand_data;
  logic               cand_last;

  // while a packet is locked only its owner may be picked
  assign lock_mask = NUM_REQ'(1) << grant_id;
  assign elig      = lock_active ? (req_valid & lock_mask) : req_valid;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .mask  (elig),
    .ptr   (ptr),
    .grant (cand_oh),
    .idx   (cand_idx),
    .found (cand_found)
  );

  assign accept      = (state == ST_IDLE) && uart_tx_ready && cand_found;
  assign req_ready   = accept ? cand_oh : '0;
  assign cand_data   = req_data[int'(cand_idx)*BYTE_W +: BYTE_W];
  assign cand_last   = req_last[cand_idx];
  assign timeout_hit = (state == ST_WAIT_BUSY) && uart_tx_ready &&
                       (cnt == CNT_W'(BUSY_TIMEOUT - 1));
  assign busy        = (state != ST_IDLE);

  // next-state: accept -> one issue cycle -> wait for UART busy -> wait for UART ready
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (accept) state_next = ST_ISSUE;
      ST_ISSUE:     state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!uart_tx_ready)  state_next = ST_WAIT_DONE;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_WAIT_DONE: if (uart_tx_ready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // state register, byte/grant capture, lock tracking and busy-timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      uart_wr     <= 1'b0;
      uart_din    <= '0;
      grant_id    <= '0;
      lock_active <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_next;
      uart_wr <= accept;
      if (accept) begin
        uart_din    <= cand_data;
        grant_id    <= cand_idx;
        ptr         <= cand_idx;
        lock_active <= ~cand_last;
      end
      case (state)
        ST_ISSUE: cnt <= '0;
        ST_WAIT_BUSY: begin
          if (uart_tx_ready) begin
            if (timeout_hit) begin
              // byte is dropped, not retried; the lock cannot outlive a dead UART
              timeout_err <= 1'b1;
              lock_active <= 1'b0;
            end else if (cnt != {CNT_W{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int BT    = 8;
  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        uart_wr;
  logic [7:0]  uart_din;
  logic        uart_tx_ready;
  logic [1:0]  grant_id;
  logic        busy, lock_active, timeout_err;

  int checks   = 0;
  int failures = 0;

  // UART model (shortened frame): TX_ready drops 2 cycles after WR is sampled
  logic stuck     = 1'b0;
  logic force_low = 1'b0;
  int   start_dly = 0;
  int   frame_cnt = 0;

  always #5 clk = ~clk;

  // UART busy model, not reset by rst
  always @(posedge clk) begin
    if (uart_wr) start_dly <= 2;
    else if (start_dly > 0) start_dly <= start_dly - 1;
    if (start_dly == 1) frame_cnt <= FRAME;
    else if (frame_cnt > 0) frame_cnt <= frame_cnt - 1;
  end

  assign uart_tx_ready = force_low ? 1'b0 : (stuck ? 1'b1 : (frame_cnt == 0));

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (BT),
    .ID_W         (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_wr       (uart_wr),
    .uart_din      (uart_din),
    .uart_tx_ready (uart_tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .lock_active   (lock_active),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  exp_oh;
    logic [7:0]  exp_data;
    logic [1:0]  exp_grant;
    logic        exp_lock;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_accept(output logic ok, output logic [3:0] oh);
    ok = 1'b0;
    oh = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        oh = req_ready;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_idle"}, seen, 1'b1);
  endtask

  task automatic send_check(input string name, input logic [3:0] exp_oh, input logic [7:0] exp_data,
                            input logic [1:0] exp_grant, input logic exp_lock);
    logic       ok;
    logic [3:0] oh;
    wait_accept(ok, oh);
    chk({name, "_accept"}, ok, 1'b1);
    if (!ok) return;
    chk({name, "_ready"}, oh, exp_oh);
    @(negedge clk);
    chk({name, "_wr"}, uart_wr, 1'b1);
    chk({name, "_din"}, uart_din, exp_data);
    chk({name, "_grant"}, grant_id, exp_grant);
    chk({name, "_lock"}, lock_active, exp_lock);
    chk({name, "_busy"}, busy, 1'b1);
    chk({name, "_ready_pulse"}, req_ready, 4'b0000);
    @(negedge clk);
    chk({name, "_wr_pulse"}, uart_wr, 1'b0);
    wait_idle(name);
    chk({name, "_din_hold"}, uart_din, exp_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    logic [3:0] oh;
    int         cycles;
    int         bad;
    logic       seen;

    tbl[0]  = '{4'b1111, 4'b1111, 32'h13121110, 4'b0001, 8'h10, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 32'h13121110, 4'b0010, 8'h11, 2'd1, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 32'h13121110, 4'b0100, 8'h12, 2'd2, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 32'h13121110, 4'b1000, 8'h13, 2'd3, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 32'h13121110, 4'b0001, 8'h10, 2'd0, 1'b0};
    tbl[5]  = '{4'b0110, 4'b1111, 32'h13121110, 4'b0010, 8'h11, 2'd1, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1111, 32'h13121110, 4'b1000, 8'h13, 2'd3, 1'b0};
    tbl[7]  = '{4'b0001, 4'b1111, 32'h13121110, 4'b0001, 8'h10, 2'd0, 1'b0};
    tbl[8]  = '{4'b0011, 4'b1101, 32'h1312A0B0, 4'b0010, 8'hA0, 2'd1, 1'b1};
    tbl[9]  = '{4'b0011, 4'b1101, 32'h1312A1B0, 4'b0010, 8'hA1, 2'd1, 1'b1};
    tbl[10] = '{4'b0011, 4'b1111, 32'h1312A2B0, 4'b0010, 8'hA2, 2'd1, 1'b0};
    tbl[11] = '{4'b0011, 4'b1111, 32'h1312A2B0, 4'b0001, 8'hB0, 2'd0, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr", uart_wr, 1'b0);
    chk("rst_din", uart_din, 8'h00);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_lock", lock_active, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // single byte from requester 2
    req_valid = 4'b0100;
    req_last  = 4'b1111;
    req_data  = 32'h00410000;
    send_check("single", 4'b0100, 8'h41, 2'd2, 1'b0);
    req_valid = '0;

    // round robin and packet lock table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      req_last  = tbl[i].last;
      req_data  = tbl[i].data;
      send_check($sformatf("vec%0d", i), tbl[i].exp_oh, tbl[i].exp_data,
                 tbl[i].exp_grant, tbl[i].exp_lock);
    end
    req_valid = '0;

    // not-ready gating
    @(negedge clk);
    force_low = 1'b1;
    req_valid = 4'b1111;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000 || uart_wr) bad++;
    end
    chk("gate_no_activity", bad, 0);
    req_valid = '0;
    force_low = 1'b0;

    // busy timeout with a UART that never goes busy; lock from last=0 is dropped
    @(negedge clk);
    stuck     = 1'b1;
    req_valid = 4'b1000;
    req_last  = 4'b0111;
    req_data  = 32'h55000000;
    wait_accept(ok, oh);
    chk("to_accept", ok, 1'b1);
    @(negedge clk);
    req_valid = '0;
    chk("to_wr", uart_wr, 1'b1);
    chk("to_grant", grant_id, 2'd3);
    chk("to_lock_set", lock_active, 1'b1);
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cycles++;
      if (timeout_err) break;
    end
    chk("to_latency", cycles, BT + 1);
    chk("to_idle", busy, 1'b0);
    chk("to_lock_clr", lock_active, 1'b0);
    req_valid = 4'b0001;
    req_last  = 4'b1111;
    req_data  = 32'h00000066;
    wait_accept(ok, oh);
    chk("to_next_accept", ok, 1'b1);
    @(negedge clk);
    req_valid = '0;
    chk("to_next_din", uart_din, 8'h66);
    chk("to_next_grant", grant_id, 2'd0);
    chk("to_sticky", timeout_err, 1'b1);
    wait_idle("to_next");
    chk("to_sticky2", timeout_err, 1'b1);
    stuck = 1'b0;

    // reset in WAIT_DONE with a lock held by requester 3
    req_valid = 4'b1000;
    req_last  = 4'b0111;
    req_data  = 32'h77000000;
    wait_accept(ok, oh);
    chk("mr_accept", ok, 1'b1);
    @(negedge clk);
    req_valid = '0;
    chk("mr_grant", grant_id, 2'd3);
    chk("mr_lock", lock_active, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && !uart_tx_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mr_uart_busy", seen, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", busy, 1'b0);
    chk("mr_lock_clr", lock_active, 1'b0);
    chk("mr_terr_clr", timeout_err, 1'b0);
    chk("mr_wr", uart_wr, 1'b0);
    req_valid = 4'b1001;
    req_last  = 4'b1111;
    req_data  = 32'h88000099;
    #1;
    chk("mr_gated", req_ready, 4'b0000);
    send_check("mr_rr", 4'b0001, 8'h99, 2'd0, 1'b0);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
